// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
// Request fields are held stable by the master until mem_ready is sampled high.
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// RV32IM memory-access stage: byte-lane steering, req/ready bus handshake, timeout abort.
// Optional MEM_MISALIGN_TRAP_EN adds misalign_fault and suppresses misaligned bus accesses.
//
// state  | meaning
// IDLE   | accepting from execute; pass-through results retire here
// ACCESS | bus request outstanding, waiting for mem_ready or timeout
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ex_result,
    input  logic [31:0] store_data,
    input  logic [2:0]  funct3,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [4:0]  rd_in,
    output logic        out_valid,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        bus_error,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalign_fault,
`endif
    mem_stage_if.master mem
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       acc_f3;
    logic [1:0]       acc_lane;
    logic [4:0]       acc_rd;
    logic             acc_load;

    logic        mem_op, misaligned;
    logic        start_access, finish_ok, finish_to, trap;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign mem_op   = is_load | is_store;
    assign in_ready = (state == IDLE);

`ifdef MEM_MISALIGN_TRAP_EN
    // funct3[1] set means word (including the reserved encodings), else [0] means half
    assign misaligned = funct3[1] ? (ex_result[1:0] != 2'b00)
                                  : (funct3[0] & ex_result[0]);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_next   = state;
        start_access = 1'b0;
        finish_ok    = 1'b0;
        finish_to    = 1'b0;
        trap         = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && mem_op) begin
                    if (misaligned) begin
                        trap = 1'b1;
                    end else begin
                        start_access = 1'b1;
                        state_next   = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // a ready seen in the timeout cycle still completes normally
                if (mem.mem_ready) begin
                    finish_ok  = 1'b1;
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    finish_to  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        st_wdata = store_data;
        st_wstrb = 4'b1111;
        if (!funct3[1]) begin
            if (funct3[0]) begin
                st_wdata = {2{store_data[15:0]}};
                st_wstrb = 4'b0011 << {ex_result[1], 1'b0};
            end else begin
                st_wdata = {4{store_data[7:0]}};
                st_wstrb = 4'b0001 << ex_result[1:0];
            end
        end
    end

    always_comb begin
        byte_sel  = mem.mem_rdata[{acc_lane, 3'b000} +: 8];
        half_sel  = mem.mem_rdata[{acc_lane[1], 4'b0000} +: 16];
        load_data = mem.mem_rdata;
        if (!acc_f3[1]) begin
            if (acc_f3[0])
                load_data = {{16{half_sel[15] & ~acc_f3[2]}}, half_sel};
            else
                load_data = {{24{byte_sel[7] & ~acc_f3[2]}}, byte_sel};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_rd        <= '0;
            bus_error     <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= '0;
            cnt           <= '0;
            acc_f3        <= '0;
            acc_lane      <= '0;
            acc_rd        <= '0;
            acc_load      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_fault <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            bus_error <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_fault <= 1'b0;
`endif
            if (state == IDLE && in_valid && !mem_op) begin
                out_valid  <= 1'b1;
                out_result <= ex_result;
                out_rd     <= rd_in;
            end
            if (trap) begin
                // faulting address goes out as the result for mtval
                out_valid  <= 1'b1;
                out_result <= ex_result;
                out_rd     <= rd_in;
`ifdef MEM_MISALIGN_TRAP_EN
                misalign_fault <= 1'b1;
`endif
            end
            if (start_access) begin
                acc_f3        <= funct3;
                acc_lane      <= ex_result[1:0];
                acc_rd        <= rd_in;
                acc_load      <= is_load;
                cnt           <= '0;
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= ~is_load;
                mem.mem_addr  <= {ex_result[31:2], 2'b00};
                mem.mem_wdata <= st_wdata;
                mem.mem_wstrb <= is_load ? 4'b0000 : st_wstrb;
            end
            if (finish_ok) begin
                mem.mem_req <= 1'b0;
                out_valid   <= 1'b1;
                out_result  <= acc_load ? load_data : 32'd0;
                out_rd      <= acc_rd;
            end else if (finish_to) begin
                mem.mem_req <= 1'b0;
                out_valid   <= 1'b1;
                bus_error   <= 1'b1;
                out_result  <= '0;
                out_rd      <= acc_rd;
            end else if (state == ACCESS) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes expected results and bus plans,
// a bus responder and an output monitor check them independently.
module tb_mem_stage;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] ex_result = '0;
    logic [31:0] store_data = '0;
    logic [2:0]  funct3 = '0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [4:0]  rd_in = '0;
    logic        out_valid;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        bus_error;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_fault;
`endif

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ex_result(ex_result), .store_data(store_data), .funct3(funct3),
        .is_load(is_load), .is_store(is_store), .rd_in(rd_in),
        .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd),
        .bus_error(bus_error),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_fault(misalign_fault),
`endif
        .mem(bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        berr;
        logic        mis;
        int          lat;
        int          t0;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          d;
        logic [31:0] rdata;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Reference: architectural load semantics from the returned word
    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] r);
        logic [31:0] bw, hw;
        bw = r >> (8 * a);
        hw = r >> (8 * (a & 2'b10));
        case (f3)
            3'b000:  return 32'($signed(bw[7:0]));
            3'b001:  return 32'($signed(hw[15:0]));
            3'b100:  return {24'd0, bw[7:0]};
            3'b101:  return {16'd0, hw[15:0]};
            default: return r;
        endcase
    endfunction

    function automatic bit is_misaligned(input logic [2:0] f3, input logic [1:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        if (f3 == 3'b001 || f3 == 3'b101) return a[0];
        if (f3 != 3'b000 && f3 != 3'b100) return a != 2'b00;
`endif
        return 1'b0;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_err++;
            $display("FAIL in_ready_wait: got 0 expected 1 within 60 cycles");
        end
    endtask

    task automatic issue(input logic [31:0] ex, input logic [31:0] sd, input logic [2:0] f3,
                         input logic ld, input logic st, input logic [4:0] rd,
                         input int d, input logic [31:0] rdata, input bit keep_exp);
        exp_t  e;
        plan_t p;
        logic [1:0] a;
        int acc;
        wait_ready();
        a = ex[1:0];
        in_valid = 1'b1; ex_result = ex; store_data = sd; funct3 = f3;
        is_load = ld; is_store = st; rd_in = rd;
        e.t0 = cyc; e.rd = rd; e.berr = 1'b0; e.mis = 1'b0;
        if (!(ld || st)) begin
            e.result = ex; e.lat = 1;
        end else if (is_misaligned(f3, a)) begin
            e.result = ex; e.lat = 1; e.mis = 1'b1;
        end else begin
            p.addr = {ex[31:2], 2'b00}; p.we = !ld; p.d = d; p.rdata = rdata;
            if (f3 == 3'b000 || f3 == 3'b100) begin
                p.wdata = {4{sd[7:0]}}; p.wstrb = 4'(1 << a);
            end else if (f3 == 3'b001 || f3 == 3'b101) begin
                p.wdata = {2{sd[15:0]}}; p.wstrb = 4'(3 << (a & 2'b10));
            end else begin
                p.wdata = sd; p.wstrb = 4'hF;
            end
            if (ld) p.wstrb = 4'h0;
            plan_q.push_back(p);
            acc = (d + 1 <= TO) ? d + 1 : TO;
            e.lat = acc + 1;
            if (d + 1 > TO) begin
                e.berr = 1'b1; e.result = 32'd0;
            end else begin
                e.result = ld ? load_model(f3, a, rdata) : 32'd0;
            end
        end
        if (keep_exp) exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Bus responder: pops a plan per new request, checks fields held, answers after d cycles
    initial begin
        plan_t cur;
        bit    active = 1'b0;
        int    k = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.mem_req) begin
                if (!active) begin
                    active = 1'b1; k = 0;
                    if (plan_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_req: got mem_req=1 expected 0 addr=0x%08h", bus.mem_addr);
                        cur.addr = bus.mem_addr; cur.we = bus.mem_we; cur.wdata = bus.mem_wdata;
                        cur.wstrb = bus.mem_wstrb; cur.d = 0; cur.rdata = '0;
                    end else begin
                        cur = plan_q.pop_front();
                    end
                end
                check("mem_addr", bus.mem_addr, cur.addr);
                check("mem_we", 32'(bus.mem_we), 32'(cur.we));
                check("mem_wstrb", 32'(bus.mem_wstrb), 32'(cur.wstrb));
                if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
                check("in_ready_busy", 32'(in_ready), 32'd0);
                k++;
                bus.mem_ready = (k == cur.d + 1);
                bus.mem_rdata = bus.mem_ready ? cur.rdata : $urandom;
            end else begin
                active = 1'b0;
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom;
            end
        end
    end

    // Output monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: got out_valid=1 result=0x%08h expected none", out_result);
                end else begin
                    e = exp_q.pop_front();
                    check("out_result", out_result, e.result);
                    check("out_rd", 32'(out_rd), 32'(e.rd));
                    check("bus_error", 32'(bus_error), 32'(e.berr));
                    check("latency", 32'(cyc - e.t0), 32'(e.lat));
`ifdef MEM_MISALIGN_TRAP_EN
                    check("misalign_fault", 32'(misalign_fault), 32'(e.mis));
`endif
                end
            end
        end
    end

    initial begin
        logic [2:0] f3;
        logic       ld, st;
        int         kind;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_result", out_result, 32'd0);
        check("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'h1234_5678, 32'h0, 3'b010, 1'b0, 1'b0, 5'd5, 0, 32'h0, 1'b1);
        issue(32'h0000_0103, 32'h0, 3'b000, 1'b1, 1'b0, 5'd1, 0, 32'h80AB_CDEF, 1'b1);
        issue(32'h0000_0202, 32'h0, 3'b101, 1'b1, 1'b0, 5'd2, 3, 32'hBEEF_0000, 1'b1);
        issue(32'h0000_0011, 32'hAA, 3'b000, 1'b0, 1'b1, 5'd3, 1, 32'h0, 1'b1);
        issue(32'h0000_0012, 32'h1234, 3'b001, 1'b0, 1'b1, 5'd4, 0, 32'h0, 1'b1);
        issue(32'h0000_0400, 32'h0, 3'b010, 1'b1, 1'b0, 5'd6, 20, 32'h1111_1111, 1'b1);
        issue(32'h0000_0404, 32'h0, 3'b010, 1'b1, 1'b0, 5'd7, 3, 32'hCAFE_F00D, 1'b1);
        issue(32'h0000_0408, 32'h5555_AAAA, 3'b010, 1'b1, 1'b1, 5'd8, 0, 32'h0BAD_BEEF, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
        issue(32'h0000_0006, 32'h0, 3'b010, 1'b1, 1'b0, 5'd9, 0, 32'h0, 1'b1);
`endif

        // Reset while a request is outstanding
        issue(32'h0000_0500, 32'h0, 3'b010, 1'b1, 1'b0, 5'd10, 40, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_mem_req", 32'(bus.mem_req), 32'd0);
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        check("rstmid_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            f3 = 3'($urandom_range(0, 7));
            ld = (kind >= 2) && (kind <= 6);
            st = (kind >= 5);
            issue($urandom, $urandom, f3, ld, st, 5'($urandom), $urandom_range(0, 6), $urandom, 1'b1);
        end

        repeat (20) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("plan_q_empty", 32'(plan_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end
endmodule
